// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage                                                    |
// | Purpose  : RISC-V instruction fetch. Holds the PC and issues one          |
// |            instruction-memory request at a time. The returned            |
// |            instruction is registered into the decode slot. A one-entry   |
// |            skid buffer absorbs decode stalls, and redirects from         |
// |            downstream flush in-flight work.                              |
// | Ports    : clk, reset (sync, active-high)                                 |
// |            PCSrc/PCTarget   - redirect request and target                 |
// |            Stall            - decode cannot accept                        |
// |            imem_req/addr/ready, imem_rvalid/rdata - memory handshake      |
// |            InstrD/PCD/PCPlus4D/ValidD - decode slot                       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [1:0]  c_st_fetch = 2'd0;
    localparam logic [1:0]  c_st_wait  = 2'd1;
    localparam logic [1:0]  c_st_full  = 2'd2;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic [1:0]  r_state,      w_state_nxt;
    logic [31:0] r_pcf,        w_pcf_nxt;
    logic        r_discard,    w_discard_nxt;
    logic        r_valid,      w_valid_nxt;
    logic [31:0] r_instr,      w_instr_nxt;
    logic [31:0] r_pcd,        w_pcd_nxt;
    logic [31:0] r_pcp4,       w_pcp4_nxt;
    logic [31:0] r_skid_instr, w_skid_instr_nxt;
    logic [31:0] r_skid_pc,    w_skid_pc_nxt;

    logic        w_slot_free;
    logic [31:0] w_pcf_plus4;
    logic [31:0] w_skid_plus4;

    assign w_slot_free  = !r_valid || !Stall;
    assign w_pcf_plus4  = r_pcf + 32'd4;
    assign w_skid_plus4 = r_skid_pc + 32'd4;

    always_comb begin
        w_state_nxt      = r_state;
        w_pcf_nxt        = r_pcf;
        w_discard_nxt    = r_discard;
        w_valid_nxt      = r_valid;
        w_instr_nxt      = r_instr;
        w_pcd_nxt        = r_pcd;
        w_pcp4_nxt       = r_pcp4;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        // Decode consumed its instruction; cleared unless something reloads it below.
        if (r_valid && !Stall) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            c_st_fetch: begin
                if (imem_ready) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (imem_rvalid) begin
                    if (r_discard) begin
                        // PCF was already redirected when discard was set.
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = c_st_fetch;
                    end else if (w_slot_free) begin
                        w_instr_nxt = imem_rdata;
                        w_pcd_nxt   = r_pcf;
                        w_pcp4_nxt  = w_pcf_plus4;
                        w_valid_nxt = 1'b1;
                        w_pcf_nxt   = w_pcf_plus4;
                        w_state_nxt = c_st_fetch;
                    end else begin
                        w_skid_instr_nxt = imem_rdata;
                        w_skid_pc_nxt    = r_pcf;
                        w_pcf_nxt        = w_pcf_plus4;
                        w_state_nxt      = c_st_full;
                    end
                end
            end
            c_st_full: begin
                if (w_slot_free) begin
                    w_instr_nxt = r_skid_instr;
                    w_pcd_nxt   = r_skid_pc;
                    w_pcp4_nxt  = w_skid_plus4;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = c_st_fetch;
                end
            end
            default: begin
                w_state_nxt = c_st_fetch;
            end
        endcase

        // Redirect overrides the normal flow: flush decode regardless of Stall,
        // drop any buffered entry, and arrange for the in-flight response (if
        // any) to be thrown away.
        if (PCSrc) begin
            w_pcf_nxt   = PCTarget;
            w_valid_nxt = 1'b0;
            case (r_state)
                c_st_fetch: begin
                    if (imem_ready) begin
                        // The old-address request was accepted this same cycle.
                        w_state_nxt   = c_st_wait;
                        w_discard_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = c_st_fetch;
                        w_discard_nxt = 1'b0;
                    end
                end
                c_st_wait: begin
                    if (imem_rvalid) begin
                        w_state_nxt   = c_st_fetch;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = c_st_wait;
                        w_discard_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = c_st_fetch;
                    w_discard_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_fetch;
            r_pcf        <= RESET_PC;
            r_discard    <= 1'b0;
            r_valid      <= 1'b0;
            r_instr      <= c_nop;
            r_pcd        <= 32'd0;
            r_pcp4       <= 32'd0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pcf        <= w_pcf_nxt;
            r_discard    <= w_discard_nxt;
            r_valid      <= w_valid_nxt;
            r_instr      <= w_instr_nxt;
            r_pcd        <= w_pcd_nxt;
            r_pcp4       <= w_pcp4_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

    // Gated by reset so no request is visible while reset is held.
    assign imem_req  = (r_state == c_st_fetch) && !reset;
    assign imem_addr = r_pcf;
    assign InstrD    = r_instr;
    assign PCD       = r_pcd;
    assign PCPlus4D  = r_pcp4;
    assign ValidD    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                 |
// | Purpose  : Directed self-checking bench for fetch_stage, covering the     |
// |            streaming path, stall/skid, redirects, PC wrap and reset.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

    logic        clk;
    logic        reset, PCSrc, Stall, imem_ready, imem_rvalid;
    logic [31:0] PCTarget, imem_rdata;
    logic        imem_req, ValidD;
    logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

    logic        reset1, imem_ready1, imem_rvalid1;
    logic [31:0] imem_rdata1;
    logic        imem_req1, ValidD1;
    logic [31:0] imem_addr1, InstrD1, PCD1, PCPlus4D1;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall(Stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset1), .PCSrc(1'b0), .PCTarget(32'd0), .Stall(1'b0),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ready(imem_ready1),
        .imem_rvalid(imem_rvalid1), .imem_rdata(imem_rdata1),
        .InstrD(InstrD1), .PCD(PCD1), .PCPlus4D(PCPlus4D1), .ValidD(ValidD1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept the pending request, then return data one cycle later.
    task automatic fetch_resp(input logic [31:0] data);
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, ValidD}, {31'd0, v});
        chk({tag, "_pcd"},   PCD,      pc);
        chk({tag, "_pcp4"},  PCPlus4D, pc + 32'd4);
        chk({tag, "_instr"}, InstrD,   ins);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
        if (r) chk({tag, "_addr"}, imem_addr, a);
    endtask

    initial begin
        reset = 1'b1; PCSrc = 1'b0; PCTarget = 32'd0; Stall = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        reset1 = 1'b1; imem_ready1 = 1'b0; imem_rvalid1 = 1'b0; imem_rdata1 = 32'd0;

        // Reset state
        step(); step();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ValidD},   32'd0);
        chk("rst_instr", InstrD,   32'h0000_0013);
        chk("rst_pcd",   PCD,      32'd0);
        chk("rst_pcp4",  PCPlus4D, 32'd0);
        chk("rst_addr",  imem_addr, 32'd0);
        reset = 1'b0;
        #1;
        chk_req("rel", 1'b1, 32'h0);

        // Streaming: one instruction per two cycles
        fetch_resp(32'h0050_0093);
        chk_slot("s0", 1'b1, 32'h0, 32'h0050_0093);
        chk_req("s0", 1'b1, 32'h4);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("s0_consumed", {31'd0, ValidD}, 32'd0);
        chk_req("s0w", 1'b0, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0;
        chk_slot("s1", 1'b1, 32'h4, 32'h00A0_0113);
        chk_req("s1", 1'b1, 32'h8);

        // Stall while the 0x8 response arrives -> skid buffer
        Stall = 1'b1; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk_slot("st0", 1'b1, 32'h4, 32'h00A0_0113);
        chk_req("st0", 1'b0, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0020_81B3;
        step();
        imem_rvalid = 1'b0;
        chk_slot("st1", 1'b1, 32'h4, 32'h00A0_0113);
        chk_req("st1", 1'b0, 32'h0);
        step();
        chk_slot("st2", 1'b1, 32'h4, 32'h00A0_0113);
        chk_req("st2", 1'b0, 32'h0);
        Stall = 1'b0;
        step();
        chk_slot("st3", 1'b1, 32'h8, 32'h0020_81B3);
        chk_req("st3", 1'b1, 32'hC);

        // Redirect in the same cycle the 0xC request is accepted, with Stall held
        imem_ready = 1'b1; PCSrc = 1'b1; PCTarget = 32'h40; Stall = 1'b1;
        step();
        imem_ready = 1'b0; PCSrc = 1'b0; Stall = 1'b0;
        chk("rd0_valid", {31'd0, ValidD}, 32'd0);
        chk_req("rd0", 1'b0, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("rd1_valid", {31'd0, ValidD}, 32'd0);
        chk_req("rd1", 1'b1, 32'h40);
        fetch_resp(32'h0010_0193);
        chk_slot("rd2", 1'b1, 32'h40, 32'h0010_0193);
        chk_req("rd2", 1'b1, 32'h44);

        // Redirect during WAIT, response two cycles later is dropped
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk_req("rw0", 1'b0, 32'h0);
        PCSrc = 1'b1; PCTarget = 32'h100;
        step();
        PCSrc = 1'b0;
        chk("rw1_valid", {31'd0, ValidD}, 32'd0);
        chk_req("rw1", 1'b0, 32'h0);
        step();
        chk_req("rw2", 1'b0, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        imem_rvalid = 1'b0;
        chk("rw3_valid", {31'd0, ValidD}, 32'd0);
        chk_req("rw3", 1'b1, 32'h100);
        fetch_resp(32'h0000_0033);
        chk_slot("rw4", 1'b1, 32'h100, 32'h0000_0033);
        chk_req("rw4", 1'b1, 32'h104);

        // Redirect in FETCH without accept; stray rvalid in FETCH is ignored
        PCSrc = 1'b1; PCTarget = 32'h200;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        PCSrc = 1'b0;
        chk_req("rf0", 1'b1, 32'h200);
        chk("rf0_valid", {31'd0, ValidD}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        chk_req("rf1", 1'b1, 32'h200);
        chk("rf1_valid", {31'd0, ValidD}, 32'd0);

        // Reset while in WAIT
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk_req("rwt0", 1'b0, 32'h0);
        reset = 1'b1;
        step();
        chk("rwt1_valid", {31'd0, ValidD}, 32'd0);
        chk("rwt1_instr", InstrD, 32'h0000_0013);
        chk("rwt1_req",   {31'd0, imem_req}, 32'd0);
        chk("rwt1_addr",  imem_addr, 32'h0);
        reset = 1'b0;
        #1;
        chk_req("rwt2", 1'b1, 32'h0);
        fetch_resp(32'h0050_0093);
        chk_slot("rwt3", 1'b1, 32'h0, 32'h0050_0093);

        // Reset while in FULL, with Stall and PCSrc also asserted
        Stall = 1'b1; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        step();
        imem_rvalid = 1'b0;
        chk_req("rfl0", 1'b0, 32'h0);
        chk("rfl0_pcd", PCD, 32'h0);
        reset = 1'b1; PCSrc = 1'b1; PCTarget = 32'h300;
        step();
        reset = 1'b0; PCSrc = 1'b0; Stall = 1'b0;
        #1;
        chk("rfl1_valid", {31'd0, ValidD}, 32'd0);
        chk("rfl1_instr", InstrD, 32'h0000_0013);
        chk("rfl1_pcd",   PCD, 32'h0);
        chk("rfl1_pcp4",  PCPlus4D, 32'h0);
        chk_req("rfl1", 1'b1, 32'h0);
        fetch_resp(32'h00A0_0113);
        chk_slot("rfl2", 1'b1, 32'h0, 32'h00A0_0113);
        chk_req("rfl2", 1'b1, 32'h4);

        // PC wrap with RESET_PC = 0xFFFF_FFFC
        reset1 = 1'b0;
        #1;
        chk("wr0_req",  {31'd0, imem_req1}, 32'd1);
        chk("wr0_addr", imem_addr1, 32'hFFFF_FFFC);
        imem_ready1 = 1'b1;
        step();
        imem_ready1 = 1'b0;
        imem_rvalid1 = 1'b1; imem_rdata1 = 32'h0000_0013;
        step();
        imem_rvalid1 = 1'b0;
        chk("wr1_valid", {31'd0, ValidD1}, 32'd1);
        chk("wr1_pcd",   PCD1, 32'hFFFF_FFFC);
        chk("wr1_pcp4",  PCPlus4D1, 32'h0);
        chk("wr1_req",   {31'd0, imem_req1}, 32'd1);
        chk("wr1_addr",  imem_addr1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the RISC-V core. Holds the program counter, issues one instruction-memory request at a time over a request/response handshake, and registers the returned instruction into the decode slot whose opcode field (InstrD[6:0]) drives the main decoder. Taken branches and jumps from downstream redirect the PC and flush in-flight work. A one-entry skid buffer absorbs decode stalls.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset; synchronous, active-high
- PCSrc  in  1  redirect request (taken branch or jal); priority over everything except reset
- PCTarget  in  32  redirect target PC, sampled when PCSrc=1
- Stall  in  1  decode cannot accept; holds decode slot when ValidD=1
- imem_req  out  1  request valid
- imem_addr  out  32  request address (= PCF)
- imem_ready  in  1  request accepted this cycle when imem_req & imem_ready
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response instruction
- InstrD  out  32  instruction in decode slot
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  decode slot holds a live instruction

## Operation
- Internal: PCF (32), state {FETCH, WAIT, FULL}, discard flag, skid buffer (instr + PC).
- Decode slot loads when free: free = !ValidD | !Stall. If slot is consumed (ValidD & !Stall) with nothing new to load, ValidD <= 0.
- FETCH: imem_req=1, imem_addr=PCF. On imem_ready -> WAIT. imem_rvalid in FETCH is ignored.
- WAIT: imem_req=0. On imem_rvalid:
  - discard=1: drop response, clear discard -> FETCH (PCF already redirected).
  - slot free: InstrD<=imem_rdata, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4 -> FETCH.
  - slot not free: store rdata/PCF in skid buffer, PCF<=PCF+4 -> FULL.
- FULL: imem_req=0. When slot free: move buffer to decode slot, ValidD<=1 -> FETCH.
- Redirect (PCSrc=1), any state: PCF<=PCTarget; ValidD<=0 (flush, ignores Stall); skid buffer dropped.
  - FETCH, no accept: stay FETCH; next request uses PCTarget.
  - FETCH with imem_ready same cycle: old-address request is accepted -> WAIT with discard=1.
  - WAIT without rvalid: discard<=1, stay WAIT. WAIT with rvalid same cycle: drop response -> FETCH.
  - FULL: -> FETCH.
- PC arithmetic: 32-bit modulo, 0xFFFF_FFFC + 4 wraps to 0x0000_0000. PCTarget used verbatim (no alignment check).
- At most one outstanding request; the instruction memory shares reset, so no response arrives for a request issued before reset.

## Timing
- Reset values: PCF=RESET_PC, state=FETCH, discard=0, ValidD=0, InstrD=32'h0000_0013 (nop), PCD=0, PCPlus4D=0. imem_req=0 while reset=1; imem_req=1 in the first cycle after reset release.
- Reset mid-operation (any state, with PCSrc or Stall): reset wins; all state returns to reset values next edge.
- Best case: request accepted cycle n, rvalid cycle n+1, ValidD=1 with instruction from cycle n+2; next request issued cycle n+2. Peak throughput: one instruction per 2 cycles.
- Stall never drops or duplicates an instruction; the stalled instruction stays on InstrD/PCD until the cycle Stall=0 is sampled.
- Flush latency: ValidD=0 in the cycle after PCSrc=1; first request to PCTarget issued no later than the cycle after the discarded response.
- imem_addr is stable while imem_req=1 and not accepted, except on redirect.

## Test plan
- Reset, imem_ready=1, 1-cycle rvalid with rdata=0x00500093,0x00A00113,0x002081B3 -> ValidD pulses with PCD=0x0,0x4,0x8, PCPlus4D=0x4,0x8,0xC, InstrD matches, one instruction per 2 cycles.
- Stall=1 while ValidD=1 (PCD=0x4) and response for 0x8 arrives -> InstrD/PCD hold 0x4 entry, state FULL, imem_req=0; Stall=0 -> next cycle PCD=0x8, then request to 0xC.
- PCSrc=1, PCTarget=0x100 during WAIT for 0x8, rvalid two cycles later -> ValidD=0, response dropped, next imem_addr=0x100, next ValidD entry has PCD=0x100.
- PCSrc=1 same cycle as imem_req&imem_ready at 0xC (PCTarget=0x40) -> 0xC response discarded, next request 0x40; PCSrc=1 with Stall=1 and ValidD=1 -> ValidD=0 next cycle.
- RESET_PC=0xFFFF_FFFC -> first request 0xFFFF_FFFC, PCPlus4D=0x0, second request 0x0.
- Assert reset in WAIT and in FULL -> next cycle ValidD=0, InstrD=0x00000013, imem_addr=RESET_PC, fetch restarts cleanly.
